// File: rtl/d_branch_ctrl.sv
// d_branch_ctrl: D-stage branch sequencer.
// Stalls F/D until the branch operands are final. It then issues one
// taken/not-taken decision per branch to NPC, and keeps presenting that
// decision while a downstream stall holds the D stage frozen.
// Build option: define BRANCH_STAT_EN to get live stat_br/stat_taken/stat_stall
// counters. Without it those ports read 0 and no counter flops exist.
module d_branch_ctrl #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  D_br_type,
  input  logic        D_opnd_ready,
  input  logic        D_hold,
  input  logic        Beq_judge,
  input  logic        Bne_judge,
  output logic        D_br_stall,
  output logic        br_valid,
  output logic        br_taken,
  output logic        br_hang,
  output logic [31:0] stat_br,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_stall
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [WAIT_W-1:0] WaitCntMax  = '1;
  localparam logic [WAIT_W-1:0] WaitCntOne  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] MaxWaitCnt  = WAIT_W'(MAX_WAIT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              hang_q, hang_d;
  logic              taken_q, taken_d;

  logic isBeq;
  logic isBne;
  logic isBr;
  logic cond;

  logic stallRaw;
  logic validRaw;
  logic takenRaw;
  logic resolve;

  // Decode the branch kind; the reserved encoding behaves as "no branch"
  always_comb begin
    isBeq = (D_br_type == 2'b01);
    isBne = (D_br_type == 2'b10);
    isBr  = isBeq | isBne;
    cond  = isBeq ? Beq_judge : Bne_judge;
  end

  // Sequencer: next state, wait counter, latched decision and raw outputs
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    taken_d    = taken_q;
    stallRaw   = 1'b0;
    validRaw   = 1'b0;
    takenRaw   = 1'b0;
    resolve    = 1'b0;

    case (state_q)
      StIdle: begin
        if (isBr) begin
          if (D_opnd_ready) begin
            validRaw = 1'b1;
            takenRaw = cond;
            resolve  = 1'b1;
            taken_d  = cond;
            if (D_hold) begin
              state_d = StDone;
            end
          end else begin
            stallRaw   = 1'b1;
            state_d    = StWait;
            wait_cnt_d = WaitCntOne;
          end
        end
      end

      StWait: begin
        if (!isBr) begin
          // Branch flushed or turned invalid while waiting: drop it silently
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if (D_opnd_ready) begin
          validRaw   = 1'b1;
          takenRaw   = cond;
          resolve    = 1'b1;
          taken_d    = cond;
          wait_cnt_d = '0;
          state_d    = D_hold ? StDone : StIdle;
        end else begin
          // A downstream hold does not pause the count; stall stays asserted
          stallRaw = 1'b1;
          if (wait_cnt_q != WaitCntMax) begin
            wait_cnt_d = wait_cnt_q + WaitCntOne;
          end
        end
      end

      StDone: begin
        // Present the latched decision; live comparator inputs are ignored here
        validRaw = 1'b1;
        takenRaw = taken_q;
        if (!D_hold) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d    = StIdle;
        wait_cnt_d = '0;
      end
    endcase

    hang_d = hang_q | (wait_cnt_d > MaxWaitCnt);
  end

  // State registers with synchronous reset; the hang flag is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      hang_q     <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hang_q     <= hang_d;
      taken_q    <= taken_d;
    end
  end

  // Outputs read 0 in any cycle where reset is asserted
  always_comb begin
    D_br_stall = stallRaw & ~reset;
    br_valid   = validRaw & ~reset;
    br_taken   = takenRaw & validRaw & ~reset;
    br_hang    = hang_q & ~reset;
  end

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_taken_q;
  logic [31:0] stat_stall_q;

  // Event counters: one resolve per branch (never in DONE), and one count per stall cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_q    <= 32'd0;
      stat_taken_q <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      if (resolve) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (resolve && takenRaw) begin
        stat_taken_q <= stat_taken_q + 32'd1;
      end
      if (stallRaw) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  // Counter outputs are masked during reset like every other output
  always_comb begin
    stat_br    = reset ? 32'd0 : stat_br_q;
    stat_taken = reset ? 32'd0 : stat_taken_q;
    stat_stall = reset ? 32'd0 : stat_stall_q;
  end
`else
  // Statistics disabled: ports are constant zero
  always_comb begin
    stat_br    = 32'd0;
    stat_taken = 32'd0;
    stat_stall = 32'd0;
  end
`endif

endmodule
